// File: rtl/sid_write_scheduler_if.sv
// Command and SID-side bus of sid_write_scheduler: two requester ports plus the SID write port.
// The scheduler uses the slave view; command sources and the SID core see the master view.
interface sid_write_scheduler_if;
    logic       a_valid;
    logic       a_ready;
    logic [4:0] a_addr;
    logic [7:0] a_data;
    logic       b_valid;
    logic       b_ready;
    logic [4:0] b_addr;
    logic [7:0] b_data;
    logic       sid_ce_1m;
    logic       sid_we;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic       busy;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, sid_ce_1m, sid_we, sid_addr, sid_data, busy
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, sid_ce_1m, sid_we, sid_addr, sid_data, busy
    );
endinterface

// File: rtl/sid_write_scheduler.sv
// Two-requester SID write arbiter with command FIFO, 1 MHz tick divider and delay interpreter.
// Optional macro SID_SCHED_PRIO_EN: requester B gets strict priority instead of round-robin.
module sid_write_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CE_DIV     = 12,
    parameter int unsigned WAIT_WIDTH = 8
) (
    input logic               clk,
    input logic               reset,
    sid_write_scheduler_if.slave bus
);
    localparam int unsigned      PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned      DIV_W      = $clog2(CE_DIV);
    localparam logic [DIV_W-1:0] DIV_TOP    = DIV_W'(CE_DIV - 1);
    localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [4:0]       DELAY_ADDR = 5'h1f;

    typedef enum logic [1:0] {StIdle, StWrite, StWait} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [DIV_W-1:0]      r_div;
    logic [12:0]           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W:0]        r_count;
    logic [WAIT_WIDTH-1:0] r_wait;
    logic                  r_last_b;
    logic [4:0]            r_sid_addr;
    logic [7:0]            r_sid_data;

    logic        w_tick;
    logic        w_slot;
    logic        w_full;
    logic        w_empty;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_push;
    logic        w_pop;
    logic [12:0] w_push_cmd;
    logic [12:0] w_head;
    logic        w_head_delay;

    assign w_tick       = (r_div == '0);
    assign w_slot       = (r_div == DIV_TOP);
    // Holding the FIFO full during reset forces both ready outputs low.
    assign w_full       = reset || (r_count == CNT_FULL);
    assign w_empty      = (r_count == '0);
    assign w_head       = r_mem[r_rptr];
    assign w_head_delay = (w_head[12:8] == DELAY_ADDR);
    assign w_pop        = w_slot && (r_state == StIdle) && (r_wait == '0) && !w_empty;

`ifdef SID_SCHED_PRIO_EN
    assign w_grant_b = !w_full && bus.b_valid;
    assign w_grant_a = !w_full && bus.a_valid && !bus.b_valid;
`else
    assign w_grant_a = !w_full && bus.a_valid && (!bus.b_valid || r_last_b);
    assign w_grant_b = !w_full && bus.b_valid && (!bus.a_valid || !r_last_b);
`endif

    assign w_push     = w_grant_a || w_grant_b;
    assign w_push_cmd = w_grant_b ? {bus.b_addr, bus.b_data} : {bus.a_addr, bus.a_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= DIV_TOP;
        end else if (w_tick) begin
            r_div <= DIV_TOP;
        end else begin
            r_div <= r_div - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_cmd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_last_b <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr   <= r_wptr + 1'b1;
                r_last_b <= w_grant_b;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait     <= '0;
            r_sid_addr <= '0;
            r_sid_data <= '0;
        end else begin
            if (w_pop && w_head_delay) begin
                r_wait <= WAIT_WIDTH'(w_head[7:0]);
            end else if ((r_state == StWait) && w_tick && (r_wait != '0)) begin
                r_wait <= r_wait - 1'b1;
            end
            if (w_pop && !w_head_delay) begin
                r_sid_addr <= w_head[12:8];
                r_sid_data <= w_head[7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A delay of N leaves WAIT on the tick edge after the count has reached zero: N+1 ticks.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_pop) w_state_next = w_head_delay ? StWait : StWrite;
            StWrite: if (w_tick) w_state_next = StIdle;
            StWait:  if (w_tick && (r_wait == '0)) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.a_ready   = w_grant_a;
        bus.b_ready   = w_grant_b;
        bus.sid_ce_1m = w_tick && !reset;
        bus.sid_we    = (r_state == StWrite);
        bus.sid_addr  = r_sid_addr;
        bus.sid_data  = r_sid_data;
        bus.busy      = !w_empty || (r_state != StIdle) || (r_wait != '0);
    end
endmodule

// File: tb/tb_sid_write_scheduler.sv
// Directed bench for sid_write_scheduler: arbitration vector table plus timing sequences.
module tb_sid_write_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   ecnt;
    int   n_checks = 0;
    int   n_fail = 0;

    sid_write_scheduler_if bus_if ();

    sid_write_scheduler #(
        .FIFO_DEPTH(4),
        .CE_DIV    (12),
        .WAIT_WIDTH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    // ecnt = number of rising edges since reset release
    always @(posedge clk or posedge reset) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    typedef struct {
        logic       av;
        logic [4:0] aa;
        logic [7:0] ad;
        logic       bv;
        logic [4:0] ba;
        logic [7:0] bd;
        logic       exp_ar;
        logic       exp_br;
    } vec_t;

    vec_t        vecs[7];
    logic [12:0] exp_wr[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [7:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [7:0] bd);
        bus_if.a_valid = av;
        bus_if.a_addr  = aa;
        bus_if.a_data  = ad;
        bus_if.b_valid = bv;
        bus_if.b_addr  = ba;
        bus_if.b_data  = bd;
    endtask

    task automatic wait_after(input int k);
        while (ecnt < k + 1) @(negedge clk);
    endtask

    // Leaves reset asserted at a falling edge; caller drives inputs and then releases.
    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 5'h0, 8'h0, 1'b0, 5'h0, 8'h0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
`ifdef SID_SCHED_PRIO_EN
        vecs[0] = '{1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 5'h04, 8'h11, 1'b1, 5'h05, 8'h22, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 5'h04, 8'h11, 1'b1, 5'h0b, 8'h2b, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 5'h04, 8'h11, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 5'h07, 8'h44, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0};
        exp_wr  = '{13'h0522, 13'h0b2b, 13'h0411, 13'h0744, 13'h0966};
`else
        vecs[0] = '{1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 5'h04, 8'h11, 1'b1, 5'h05, 8'h22, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 5'h06, 8'h33, 1'b1, 5'h05, 8'h22, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 5'h06, 8'h33, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 5'h07, 8'h44, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0};
        exp_wr  = '{13'h0411, 13'h0522, 13'h0633, 13'h0744, 13'h0966};
`endif
        vecs[5] = '{1'b1, 5'h08, 8'h55, 1'b1, 5'h09, 8'h66, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h09, 8'h66, 1'b0, 1'b0};

        // Reset state, with requesters already valid
        do_reset();
        drive(1'b1, 5'h04, 8'h11, 1'b1, 5'h05, 8'h22);
        #1;
        chk("rst_a_ready", bus_if.a_ready, 0);
        chk("rst_b_ready", bus_if.b_ready, 0);
        chk("rst_sid_we", bus_if.sid_we, 0);
        chk("rst_ce", bus_if.sid_ce_1m, 0);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_sid_addr", bus_if.sid_addr, 0);
        @(negedge clk);

        // Single write from A at cycle 0
        drive(1'b1, 5'h04, 8'h11, 1'b0, 5'h0, 8'h0);
        reset = 1'b0;
        #1;
        chk("s1_a_ready", bus_if.a_ready, 1);
        wait_after(0);
        drive(1'b0, 5'h0, 8'h0, 1'b0, 5'h0, 8'h0);
        wait_after(9);
        chk("s1_ce_e9", bus_if.sid_ce_1m, 0);
        wait_after(10);
        chk("s1_ce_first", bus_if.sid_ce_1m, 1);
        chk("s1_we_e10", bus_if.sid_we, 0);
        chk("s1_busy_q", bus_if.busy, 1);
        wait_after(11);
        chk("s1_ce_e11", bus_if.sid_ce_1m, 0);
        chk("s1_we_e11", bus_if.sid_we, 0);
        wait_after(12);
        chk("s1_we_rise", bus_if.sid_we, 1);
        chk("s1_addr", bus_if.sid_addr, 5'h04);
        chk("s1_data", bus_if.sid_data, 8'h11);
        wait_after(22);
        chk("s1_we_last", bus_if.sid_we, 1);
        chk("s1_ce_last", bus_if.sid_ce_1m, 1);
        wait_after(23);
        chk("s1_we_fall", bus_if.sid_we, 0);
        chk("s1_busy_end", bus_if.busy, 0);
        chk("s1_addr_hold", bus_if.sid_addr, 5'h04);

        // Arbitration table, then continuous requesters
        do_reset();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
            #1;
            chk($sformatf("vec%0d_a_ready", i), bus_if.a_ready, vecs[i].exp_ar);
            chk($sformatf("vec%0d_b_ready", i), bus_if.b_ready, vecs[i].exp_br);
            @(negedge clk);
        end
        drive(1'b1, 5'h08, 8'h55, 1'b1, 5'h09, 8'h66);
        wait_after(11);
        chk("rr_full_ready", {bus_if.a_ready, bus_if.b_ready}, 2'b00);
        wait_after(12);
        chk("rr_wr0", {bus_if.sid_we, bus_if.sid_addr, bus_if.sid_data}, {1'b1, exp_wr[0]});
        chk("rr_e12_ready", {bus_if.a_ready, bus_if.b_ready}, 2'b01);
        wait_after(13);
        chk("rr_e13_ready", {bus_if.a_ready, bus_if.b_ready}, 2'b00);
        drive(1'b1, 5'h08, 8'h55, 1'b1, 5'h0a, 8'h77);
        wait_after(24);
        chk("rr_wr1", {bus_if.sid_we, bus_if.sid_addr, bus_if.sid_data}, {1'b1, exp_wr[1]});
`ifdef SID_SCHED_PRIO_EN
        chk("rr_e24_ready", {bus_if.a_ready, bus_if.b_ready}, 2'b01);
`else
        chk("rr_e24_ready", {bus_if.a_ready, bus_if.b_ready}, 2'b10);
`endif
        wait_after(25);
        chk("rr_e25_ready", {bus_if.a_ready, bus_if.b_ready}, 2'b00);
        drive(1'b0, 5'h0, 8'h0, 1'b0, 5'h0, 8'h0);
        wait_after(36);
        chk("rr_wr2", {bus_if.sid_we, bus_if.sid_addr, bus_if.sid_data}, {1'b1, exp_wr[2]});
        wait_after(48);
        chk("rr_wr3", {bus_if.sid_we, bus_if.sid_addr, bus_if.sid_data}, {1'b1, exp_wr[3]});
        wait_after(60);
        chk("rr_wr4", {bus_if.sid_we, bus_if.sid_addr, bus_if.sid_data}, {1'b1, exp_wr[4]});

        // Delay of 3 ticks followed by a write of reg 18
        do_reset();
        drive(1'b1, 5'h1f, 8'h03, 1'b0, 5'h0, 8'h0);
        reset = 1'b0;
        wait_after(0);
        drive(1'b1, 5'h18, 8'h0f, 1'b0, 5'h0, 8'h0);
        wait_after(1);
        drive(1'b0, 5'h0, 8'h0, 1'b0, 5'h0, 8'h0);
        wait_after(12);
        chk("d3_no_we_pop", bus_if.sid_we, 0);
        chk("d3_busy", bus_if.busy, 1);
        wait_after(36);
        chk("d3_no_we_mid", bus_if.sid_we, 0);
        wait_after(48);
        chk("d3_no_we_e48", bus_if.sid_we, 0);
        wait_after(59);
        chk("d3_no_we_e59", bus_if.sid_we, 0);
        chk("d3_busy_e59", bus_if.busy, 1);
        wait_after(60);
        chk("d3_wr", {bus_if.sid_we, bus_if.sid_addr, bus_if.sid_data}, {1'b1, 5'h18, 8'h0f});

        // Zero delay acts as a one-tick gap
        do_reset();
        drive(1'b1, 5'h1f, 8'h00, 1'b0, 5'h0, 8'h0);
        reset = 1'b0;
        wait_after(0);
        drive(1'b1, 5'h0a, 8'h5a, 1'b0, 5'h0, 8'h0);
        wait_after(1);
        drive(1'b0, 5'h0, 8'h0, 1'b0, 5'h0, 8'h0);
        wait_after(23);
        chk("d0_no_we_e23", bus_if.sid_we, 0);
        wait_after(24);
        chk("d0_wr", {bus_if.sid_we, bus_if.sid_addr, bus_if.sid_data}, {1'b1, 5'h0a, 8'h5a});

        // Asynchronous reset while a write is in flight with 3 entries queued
        do_reset();
        drive(1'b1, 5'h01, 8'ha1, 1'b0, 5'h0, 8'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_after(i);
            drive(1'b1, 5'(i + 2), 8'(8'ha2 + i), 1'b0, 5'h0, 8'h0);
        end
        wait_after(3);
        drive(1'b0, 5'h0, 8'h0, 1'b0, 5'h0, 8'h0);
        wait_after(14);
        drive(1'b1, 5'h11, 8'hbb, 1'b1, 5'h12, 8'hcc);
        #1;
        chk("ar_pre_we", bus_if.sid_we, 1);
        chk("ar_pre_ready", {bus_if.a_ready, bus_if.b_ready}, 2'b01);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_we", bus_if.sid_we, 0);
        chk("ar_busy", bus_if.busy, 0);
        chk("ar_ready", {bus_if.a_ready, bus_if.b_ready}, 2'b00);
        drive(1'b0, 5'h0, 8'h0, 1'b0, 5'h0, 8'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        begin
            int we_seen;
            we_seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (bus_if.sid_we) we_seen++;
            end
            chk("ar_no_stale_we", 32'(we_seen), 0);
        end
        chk("ar_busy_after", bus_if.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
